wb_stream_reader: RTL and testbench
===================================

WB_STREAM_READER -- requirements
Module: wb_stream_reader

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- WB_AW, 32, Wishbone address width.
- WB_DW, 32, Wishbone and stream data width.
- FIFO_AW, 5, FIFO address width; depth is 2**FIFO_AW words.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- stream_data_i  in  WB_DW  stream word.
- stream_valid_i  in  1  stream word valid.
- stream_ready_o  out  1  stream word accepted when valid && ready.
- wbm_adr_o  out  WB_AW  byte address.
- wbm_dat_o  out  WB_DW  write data.
- wbm_sel_o  out  WB_DW/8  byte select.
- wbm_we_o  out  1  write enable.
- wbm_cyc_o  out  1  cycle.
- wbm_stb_o  out  1  strobe.
- wbm_cti_o  out  3  cycle type.
- wbm_bte_o  out  2  burst type.
- wbm_ack_i  in  1  acknowledge.
- wbm_err_i  in  1  error.
- wbm_rty_i  in  1  retry; ignored.
- enable_i  in  1  run request.
- cfg_start_adr_i  in  WB_AW  buffer base byte address.
- cfg_buf_size_i  in  WB_AW  buffer size in bytes.
- cfg_burst_size_i  in  WB_AW  burst length in words, 1..2**FIFO_AW.
- irq_o  out  1  one-cycle pulse at buffer wrap.
- err_o  out  1  sticky bus error; present only with WB_STREAM_READER_ERR_EN.

Function
REQ-003 Stream words SHALL be pushed into the FIFO on valid && ready, with stream_ready_o = !fifo_full; a full FIFO SHALL block the stream and never drop words.
REQ-004 FIFO level SHALL be FIFO_AW+1 bits wide; a simultaneous push and pop SHALL leave the level unchanged.
REQ-005 The FSM SHALL have states IDLE, WAIT and BURST.
REQ-006 IDLE->WAIT SHALL occur when enable_i=1, cfg_buf_size_i>=4 and cfg_burst_size_i!=0; on this transition the block SHALL latch the config, set adr=start, and set words_left=buf_size>>2.
REQ-007 WAIT->BURST SHALL occur when level >= blen, where blen=min(burst_size, words_left); WAIT->IDLE SHALL occur when enable_i=0.
REQ-008 In BURST the outputs SHALL be: cyc=stb=we=1, sel all ones, bte=2'b00, dat_o=FIFO head, cti=3'b010 on every beat except the last, and 3'b111 on the last beat.
REQ-009 Each ack SHALL pop one FIFO word, add 4 to adr, and decrement words_left.
REQ-010 On the last beat's ack, cyc and stb SHALL be low in the next cycle.
REQ-011 When words_left reaches 0, adr SHALL reload the latched start, words_left SHALL reload, and irq_o SHALL pulse for 1 cycle (circular buffer).
REQ-012 After a burst the FSM SHALL go to WAIT if enable_i=1, else to IDLE; deasserting enable_i mid-burst SHALL let the current burst complete.
REQ-013 All Wishbone outputs SHALL be registered; the master SHALL never issue a partial burst, except on error.
REQ-014 wbm_rty_i SHALL be ignored.

Reset
REQ-015 rst_n low SHALL asynchronously force: FSM=IDLE, FIFO empty, cyc=stb=we=0, adr=0, dat=0, sel=0, cti=0, bte=0, irq_o=0, err_o=0, stream_ready_o=0.
REQ-016 stream_ready_o SHALL rise on the first clk after rst_n is released; a reset mid-burst SHALL abort the burst and discard FIFO contents.

Configuration
REQ-017 With WB_STREAM_READER_ERR_EN defined, wbm_err_i in BURST SHALL end the cycle (cyc=stb=0 next cycle), leave the FIFO unpopped, set err_o sticky, and force IDLE; err_o SHALL clear only on reset, and IDLE SHALL not be left while err_o=1.
REQ-018 Without WB_STREAM_READER_ERR_EN, the err_o port SHALL be absent and wbm_err_i SHALL be ignored.

Structure
REQ-019 A shared package wb_stream_pkg SHALL hold the cti/bte constants (CTI_CLASSIC, CTI_INC, CTI_EOB, BTE_LINEAR) and the FSM state enum.
REQ-020 The FIFO SHALL be the single sub-module wb_stream_reader_fifo: synchronous, first-word fall-through, exposing level.

Verification
REQ-021 Stream 32 random words with buf_size=128 and burst_size=8 -> 4 bursts, addresses 0x00..0x7C, cti 010 x7 then 111, RAM contents equal the stimulus, 1 irq_o pulse.
REQ-022 Hold the Wishbone slave stalled (no ack) while streaming 40 words with FIFO_AW=5 -> stream_ready_o low after 32 words, no word lost after release.
REQ-023 buf_size=40, burst_size=8, start=0x100 -> burst of 8 then burst of 2, wrap back to 0x100, irq_o pulses once per 10 words.
REQ-024 Deassert enable_i during beat 3 of 8 -> the burst completes 8 beats, then IDLE, no further cyc.
REQ-025 Assert rst_n=0 mid-burst -> cyc/stb low asynchronously, FIFO empty, stream_ready_o high one clk after release.
REQ-026 With ERR_EN, assert err on beat 2 -> cyc low next cycle, err_o=1, no further bursts until reset.

Source files
------------

// File: rtl/wb_stream_pkg.sv
// Shared constants and FSM state type for the Wishbone stream reader.
package wb_stream_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INC     = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_BURST
    } state_t;

endpackage

// File: rtl/wb_stream_reader_fifo.sv
// First-word fall-through FIFO with level; also exposes the word after the head
// so registered burst data can advance on the same edge as a pop.
module wb_stream_reader_fifo #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic [DW-1:0] dout_next,
    output logic [AW:0]   level,
    output logic          full
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_nxt;
    logic          do_push;
    logic          do_pop;

    assign full      = (level == (AW+1)'(DEPTH));
    assign do_push   = push && !full;
    assign do_pop    = pop && (level != '0);
    assign rd_nxt    = rd_ptr + 1'b1;
    assign dout      = mem[rd_ptr];
    assign dout_next = mem[rd_nxt];

    // Storage is not reset; pointers and level define validity.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_nxt;
            unique case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/wb_stream_reader.sv
// Stream-to-Wishbone burst writer into a circular buffer.
// Optional bus-error handling: define WB_STREAM_READER_ERR_EN.
module wb_stream_reader
    import wb_stream_pkg::*;
#(
    parameter int WB_AW   = 32,
    parameter int WB_DW   = 32,
    parameter int FIFO_AW = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WB_DW-1:0]   stream_data_i,
    input  logic               stream_valid_i,
    output logic               stream_ready_o,
    output logic [WB_AW-1:0]   wbm_adr_o,
    output logic [WB_DW-1:0]   wbm_dat_o,
    output logic [WB_DW/8-1:0] wbm_sel_o,
    output logic               wbm_we_o,
    output logic               wbm_cyc_o,
    output logic               wbm_stb_o,
    output logic [2:0]         wbm_cti_o,
    output logic [1:0]         wbm_bte_o,
    input  logic               wbm_ack_i,
    input  logic               wbm_err_i,
    input  logic               wbm_rty_i,
    input  logic               enable_i,
    input  logic [WB_AW-1:0]   cfg_start_adr_i,
    input  logic [WB_AW-1:0]   cfg_buf_size_i,
    input  logic [WB_AW-1:0]   cfg_burst_size_i,
    output logic               irq_o
`ifdef WB_STREAM_READER_ERR_EN
    ,
    output logic               err_o
`endif
);

    logic [WB_DW-1:0] fifo_head;
    logic [WB_DW-1:0] fifo_next;
    logic [FIFO_AW:0] fifo_level;
    logic             fifo_full;
    logic             push;
    logic             pop;
    logic             rdy_q;
    logic             err_hit;
    logic             err_q;
    state_t           state;

    logic [WB_AW-1:0] start_q;
    logic [WB_AW-1:0] size_q;
    logic [WB_AW-1:0] burst_q;
    logic [WB_AW-1:0] left_q;
    logic [WB_AW-1:0] beats_q;
    logic [WB_AW-1:0] blen;
    logic [WB_AW-1:0] level_ext;
    logic [WB_AW-1:0] left_dec;
    logic             unused_ok;

    assign stream_ready_o = rdy_q && !fifo_full;
    assign push           = stream_valid_i && stream_ready_o;
    assign pop            = (state == ST_BURST) && wbm_ack_i && !err_hit;
    assign blen           = (burst_q < left_q) ? burst_q : left_q;
    assign level_ext      = WB_AW'(fifo_level);
    assign left_dec       = left_q - WB_AW'(1);
    assign unused_ok      = ^{wbm_rty_i, wbm_err_i, cfg_buf_size_i[1:0]};

`ifdef WB_STREAM_READER_ERR_EN
    assign err_hit = wbm_err_i;
    assign err_o   = err_q;
`else
    assign err_hit = 1'b0;
`endif

    wb_stream_reader_fifo #(
        .DW (WB_DW),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .din       (stream_data_i),
        .pop       (pop),
        .dout      (fifo_head),
        .dout_next (fifo_next),
        .level     (fifo_level),
        .full      (fifo_full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rdy_q     <= 1'b0;
            irq_o     <= 1'b0;
            err_q     <= 1'b0;
            start_q   <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            left_q    <= '0;
            beats_q   <= '0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            wbm_sel_o <= '0;
            wbm_we_o  <= 1'b0;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_cti_o <= CTI_CLASSIC;
            wbm_bte_o <= BTE_LINEAR;
        end else begin
            rdy_q <= 1'b1;
            irq_o <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (enable_i && !err_q &&
                        cfg_buf_size_i >= WB_AW'(4) &&
                        cfg_burst_size_i != '0) begin
                        start_q   <= cfg_start_adr_i;
                        size_q    <= cfg_buf_size_i >> 2;
                        burst_q   <= cfg_burst_size_i;
                        wbm_adr_o <= cfg_start_adr_i;
                        left_q    <= cfg_buf_size_i >> 2;
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!enable_i) begin
                        state <= ST_IDLE;
                    end else if (level_ext >= blen) begin
                        state     <= ST_BURST;
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        wbm_we_o  <= 1'b1;
                        wbm_sel_o <= '1;
                        wbm_bte_o <= BTE_LINEAR;
                        wbm_dat_o <= fifo_head;
                        wbm_cti_o <= (blen == WB_AW'(1)) ? CTI_EOB : CTI_INC;
                        beats_q   <= blen;
                    end
                end
                ST_BURST: begin
                    if (err_hit) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        wbm_we_o  <= 1'b0;
                        wbm_sel_o <= '0;
                        wbm_cti_o <= CTI_CLASSIC;
                        err_q     <= 1'b1;
                        state     <= ST_IDLE;
                    end else if (wbm_ack_i) begin
                        beats_q   <= beats_q - WB_AW'(1);
                        wbm_dat_o <= fifo_next;
                        wbm_cti_o <= (beats_q == WB_AW'(2)) ? CTI_EOB : CTI_INC;
                        // Buffer end: wrap to the base and flag it.
                        if (left_dec == '0) begin
                            wbm_adr_o <= start_q;
                            left_q    <= size_q;
                            irq_o     <= 1'b1;
                        end else begin
                            wbm_adr_o <= wbm_adr_o + WB_AW'(4);
                            left_q    <= left_dec;
                        end
                        if (beats_q == WB_AW'(1)) begin
                            wbm_cyc_o <= 1'b0;
                            wbm_stb_o <= 1'b0;
                            wbm_we_o  <= 1'b0;
                            wbm_sel_o <= '0;
                            wbm_cti_o <= CTI_CLASSIC;
                            state     <= enable_i ? ST_WAIT : ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_stream_reader.sv
// Directed bench for wb_stream_reader with a zero-wait Wishbone RAM slave.
// Error-path scenario is built when WB_STREAM_READER_ERR_EN is defined.
module tb_wb_stream_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] stream_data = '0;
    logic        stream_valid = 1'b0;
    logic        stream_ready;
    logic [31:0] wbm_adr;
    logic [31:0] wbm_dat;
    logic [3:0]  wbm_sel;
    logic        wbm_we;
    logic        wbm_cyc;
    logic        wbm_stb;
    logic [2:0]  wbm_cti;
    logic [1:0]  wbm_bte;
    logic        wbm_ack = 1'b0;
    logic        wbm_err = 1'b0;
    logic        wbm_rty = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] cfg_start = '0;
    logic [31:0] cfg_buf = '0;
    logic [31:0] cfg_burst = '0;
    logic        irq;
`ifdef WB_STREAM_READER_ERR_EN
    logic        err_flag;
`endif

    int errors = 0;
    int checks = 0;

    logic [31:0] stim [64];
    int idx = 0;
    int acc = 0;

    logic        stall = 1'b0;
    int          err_beat = -1;
    int          err_hits = 0;
    int          beats = 0;
    int          irq_cnt = 0;
    int          irq_at [8];
    logic [31:0] log_adr [64];
    logic [31:0] log_dat [64];
    logic [2:0]  log_cti [64];
    logic [6:0]  log_ctl [64];

    wb_stream_reader dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stream_data_i    (stream_data),
        .stream_valid_i   (stream_valid),
        .stream_ready_o   (stream_ready),
        .wbm_adr_o        (wbm_adr),
        .wbm_dat_o        (wbm_dat),
        .wbm_sel_o        (wbm_sel),
        .wbm_we_o         (wbm_we),
        .wbm_cyc_o        (wbm_cyc),
        .wbm_stb_o        (wbm_stb),
        .wbm_cti_o        (wbm_cti),
        .wbm_bte_o        (wbm_bte),
        .wbm_ack_i        (wbm_ack),
        .wbm_err_i        (wbm_err),
        .wbm_rty_i        (wbm_rty),
        .enable_i         (enable),
        .cfg_start_adr_i  (cfg_start),
        .cfg_buf_size_i   (cfg_buf),
        .cfg_burst_size_i (cfg_burst),
        .irq_o            (irq)
`ifdef WB_STREAM_READER_ERR_EN
        ,
        .err_o            (err_flag)
`endif
    );

    always #5 clk = ~clk;

    // Slave: answers each strobed beat in the same cycle, logs what it saw.
    always @(negedge clk) begin
        wbm_ack = 1'b0;
        wbm_err = 1'b0;
        if (irq) begin
            if (irq_cnt < 8)
                irq_at[irq_cnt] = beats;
            irq_cnt++;
        end
        if (wbm_cyc && wbm_stb && !stall) begin
            if (beats == err_beat) begin
                wbm_err = 1'b1;
                err_hits++;
            end else begin
                wbm_ack = 1'b1;
                if (beats < 64) begin
                    log_adr[beats] = wbm_adr;
                    log_dat[beats] = wbm_dat;
                    log_cti[beats] = wbm_cti;
                    log_ctl[beats] = {wbm_we, wbm_sel, wbm_bte};
                end
                beats++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic fill_stim();
        for (int i = 0; i < 64; i++)
            stim[i] = $urandom;
        idx = 0;
    endtask

    task automatic send(input int n);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < n && ok; i++) begin
            int t;
            t = 0;
            stream_data  = stim[idx];
            stream_valid = 1'b1;
            while (!stream_ready && t < 5000) begin
                @(negedge clk);
                t++;
            end
            if (!stream_ready) begin
                check("send_timeout", 32'd0, 32'd1);
                ok = 1'b0;
            end else begin
                @(negedge clk);
                idx++;
                acc++;
            end
        end
        stream_valid = 1'b0;
    endtask

    task automatic wait_beats(input int n, input int budget);
        int t;
        t = 0;
        while (beats < n && t < budget) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (beats < n)
            check("beat_timeout", beats, n);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n        = 1'b0;
        enable       = 1'b0;
        stall        = 1'b0;
        err_beat     = -1;
        stream_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        beats    = 0;
        irq_cnt  = 0;
        acc      = 0;
        err_hits = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready", stream_ready, 0);
        check("rst_cyc", wbm_cyc, 0);
        check("rst_stb", wbm_stb, 0);
        check("rst_we", wbm_we, 0);
        check("rst_adr", wbm_adr, 0);
        check("rst_dat", wbm_dat, 0);
        check("rst_sel", wbm_sel, 0);
        check("rst_cti_bte", {wbm_cti, wbm_bte}, 0);
        check("rst_irq", irq, 0);
`ifdef WB_STREAM_READER_ERR_EN
        check("rst_err", err_flag, 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", stream_ready, 1);

        // 32 words into a 128-byte buffer, bursts of 8
        cfg_start = 32'h0;
        cfg_buf   = 32'd128;
        cfg_burst = 32'd8;
        enable    = 1'b1;
        fill_stim();
        send(32);
        wait_beats(32, 500);
        repeat (5) @(negedge clk);
        check("t1_beats", beats, 32);
        for (int k = 0; k < 32; k++) begin
            check($sformatf("t1_adr[%0d]", k), log_adr[k], k * 4);
            check($sformatf("t1_cti[%0d]", k), log_cti[k],
                  (k % 8 == 7) ? 3'b111 : 3'b010);
            check($sformatf("t1_dat[%0d]", k), log_dat[k], stim[k]);
            check($sformatf("t1_ctl[%0d]", k), log_ctl[k], 7'b1_1111_00);
        end
        check("t1_irq_cnt", irq_cnt, 1);
        check("t1_irq_at", irq_at[0], 32);
        check("t1_idle_cyc", wbm_cyc, 0);

        // Stalled slave: FIFO fills to 32 then blocks the stream
        do_reset();
        cfg_buf   = 32'd256;
        cfg_burst = 32'd8;
        enable    = 1'b1;
        stall     = 1'b1;
        fill_stim();
        fork
            send(40);
        join_none
        repeat (80) @(negedge clk);
        check("t2_accepted", acc, 32);
        check("t2_ready_low", stream_ready, 0);
        check("t2_no_beats", beats, 0);
        check("t2_cyc_held", wbm_cyc, 1);
        stall = 1'b0;
        wait_beats(40, 2000);
        repeat (5) @(negedge clk);
        check("t2_beats", beats, 40);
        check("t2_accepted_all", acc, 40);
        for (int k = 0; k < 40; k++) begin
            check($sformatf("t2_adr[%0d]", k), log_adr[k], k * 4);
            check($sformatf("t2_dat[%0d]", k), log_dat[k], stim[k]);
        end

        // 40-byte buffer at 0x100: bursts of 8 and 2, wrap every 10 words
        do_reset();
        cfg_start = 32'h100;
        cfg_buf   = 32'd40;
        cfg_burst = 32'd8;
        enable    = 1'b1;
        fill_stim();
        send(20);
        wait_beats(20, 1000);
        repeat (5) @(negedge clk);
        check("t3_beats", beats, 20);
        for (int k = 0; k < 20; k++) begin
            int m;
            m = k % 10;
            check($sformatf("t3_adr[%0d]", k), log_adr[k], 32'h100 + m * 4);
            check($sformatf("t3_cti[%0d]", k), log_cti[k],
                  (m == 7 || m == 9) ? 3'b111 : 3'b010);
            check($sformatf("t3_dat[%0d]", k), log_dat[k], stim[k]);
        end
        check("t3_irq_cnt", irq_cnt, 2);
        check("t3_irq_at0", irq_at[0], 10);
        check("t3_irq_at1", irq_at[1], 20);

        // Enable dropped during beat 3: burst completes, then idle
        do_reset();
        cfg_start = 32'h0;
        cfg_buf   = 32'd256;
        cfg_burst = 32'd8;
        enable    = 1'b1;
        fill_stim();
        fork
            send(16);
        join_none
        wait_beats(3, 1000);
        enable = 1'b0;
        repeat (40) @(negedge clk);
        check("t4_beats", beats, 8);
        check("t4_last_cti", log_cti[7], 3'b111);
        check("t4_cyc_low", wbm_cyc, 0);
        repeat (40) @(negedge clk);
        check("t4_no_more", beats, 8);

        // Reset mid-burst aborts and flushes
        do_reset();
        cfg_start = 32'h0;
        cfg_buf   = 32'd256;
        cfg_burst = 32'd8;
        enable    = 1'b1;
        fill_stim();
        send(8);
        wait_beats(3, 1000);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_cyc_async", wbm_cyc, 0);
        check("t5_stb_async", wbm_stb, 0);
        check("t5_ready_rst", stream_ready, 0);
        @(negedge clk);
        #1;
        beats   = 0;
        irq_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_ready_rel", stream_ready, 1);
        fill_stim();
        send(8);
        wait_beats(8, 1000);
        repeat (20) @(negedge clk);
        check("t5_beats", beats, 8);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("t5_adr[%0d]", k), log_adr[k], k * 4);
            check($sformatf("t5_dat[%0d]", k), log_dat[k], stim[k]);
        end

`ifdef WB_STREAM_READER_ERR_EN
        // Bus error on beat 2 ends the cycle and locks the block
        do_reset();
        check("t6_err_clear", err_flag, 0);
        cfg_start = 32'h0;
        cfg_buf   = 32'd256;
        cfg_burst = 32'd8;
        enable    = 1'b1;
        err_beat  = 1;
        fill_stim();
        send(8);
        begin
            int t;
            t = 0;
            while (err_hits == 0 && t < 1000) begin
                @(negedge clk);
                #1;
                t++;
            end
        end
        check("t6_err_seen", err_hits, 1);
        @(negedge clk);
        #1;
        check("t6_cyc_low", wbm_cyc, 0);
        check("t6_err_o", err_flag, 1);
        repeat (50) @(negedge clk);
        check("t6_beats", beats, 1);
        check("t6_cyc_idle", wbm_cyc, 0);
        check("t6_err_sticky", err_flag, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
